// File: rtl/uart_mem_pkg.sv
// Shared constants and types for the UART-to-RAM command bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: command/reply byte codes, bridge FSM state type, and a
// saturating 8-bit increment used by the error counter.
package uart_mem_pkg;

    // Command opcodes received from the host
    localparam logic [7:0] OP_WRITE = 8'h57;  // 'W'
    localparam logic [7:0] OP_READ  = 8'h52;  // 'R'
    localparam logic [7:0] OP_BURST = 8'h42;  // 'B'

    // Reply bytes sent back to the host
    localparam logic [7:0] RSP_ACK  = 8'h4B;  // 'K'
    localparam logic [7:0] RSP_ERR  = 8'h3F;  // '?'

    typedef enum logic [3:0] {
        IDLE,
        GET_ADDR,
        GET_LEN,
        GET_DATA,
        RAM_WR,
        ACK,
        RAM_RD,
        RD_WAIT,
        SEND,
        ERR
    } state_t;

    // Increment that sticks at 255 instead of wrapping
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sp_ram.sv
// Single-port RAM, DATA_W x 2^ADDR_W, for the command bridge.
// Latency: 1-cycle registered read; write takes effect at the clock edge.
// Backpressure: none; one access per cycle.
//
// Ports: clk, we (write enable), addr, din (write data), dout (registered
// read data). No reset on purpose so the array maps onto block SRAM.
module sp_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
        dout <= mem[addr];
    end

endmodule

// File: rtl/uart_mem_bridge.sv
// UART byte-stream command bridge to an on-chip RAM (write / read / burst read).
// Latency: write ack 2 cycles after last frame byte; read data 3 cycles after.
// Backpressure: tx_data/tx_valid hold while tx_ready is low; rx has no stall,
//               bytes arriving while a command executes are dropped and counted.
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   rx_valid, rx_data     one-cycle strobe with a received byte
//   tx_data, tx_valid     reply byte to the transmitter
//   tx_ready              transmitter accepts when tx_valid && tx_ready
//   busy                  high whenever the FSM is not in IDLE
//   err_count             saturating protocol error count
module uart_mem_bridge
    import uart_mem_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 4,
    parameter int TIMEOUT_CYC = 2700000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic [7:0] err_count
);

    localparam int BYTES      = DATA_W / 8;
    localparam int ADDR_BYTES = (ADDR_W + 7) / 8;
    localparam int TMO_W      = $clog2(TIMEOUT_CYC + 1);

    state_t            state;
    logic [7:0]        opcode;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] shreg;      // remaining bytes of the word being sent
    logic [7:0]        len_cnt;    // burst words still to send after this one
    logic [7:0]        fld_cnt;    // bytes still expected in the current field
    logic [7:0]        byte_cnt;   // bytes still to send after the current one
    logic [TMO_W-1:0]  tmo_cnt;

    logic              ram_we;
    logic [DATA_W-1:0] ram_dout;

    logic              in_get;
    logic              tmo_hit;

    sp_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (addr_q),
        .din  (data_q),
        .dout (ram_dout)
    );

    // The write strobe lives for exactly the one RAM_WR cycle; reads are
    // only consumed in RD_WAIT, so read and write never overlap.
    assign ram_we = (state == RAM_WR);
    assign busy   = (state != IDLE);

    assign in_get  = (state == GET_ADDR) || (state == GET_LEN) || (state == GET_DATA);
    // A byte arriving in the expiry cycle takes priority over the timeout.
    assign tmo_hit = in_get && !rx_valid && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            opcode    <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            shreg     <= '0;
            len_cnt   <= '0;
            fld_cnt   <= '0;
            byte_cnt  <= '0;
            tmo_cnt   <= '0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            err_count <= '0;
        end else begin
            // Inter-byte timer only runs while a frame is being assembled
            if (!in_get || rx_valid || tmo_hit) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end

            // Bytes that arrive while a command executes are lost
            if (rx_valid && !in_get && (state != IDLE)) begin
                err_count <= sat_inc(err_count);
            end

            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        opcode  <= rx_data;
                        fld_cnt <= 8'(ADDR_BYTES - 1);
                        if ((rx_data == OP_WRITE) || (rx_data == OP_READ) ||
                            (rx_data == OP_BURST)) begin
                            state <= GET_ADDR;
                        end else begin
                            tx_data   <= RSP_ERR;
                            tx_valid  <= 1'b1;
                            err_count <= sat_inc(err_count);
                            state     <= ERR;
                        end
                    end
                end

                GET_ADDR: begin
                    if (rx_valid) begin
                        // MSB-first shift; bits above ADDR_W fall off the top
                        addr_q <= ADDR_W'({addr_q, rx_data});
                        if (fld_cnt == 8'd0) begin
                            case (opcode)
                                OP_WRITE: begin
                                    fld_cnt <= 8'(BYTES - 1);
                                    state   <= GET_DATA;
                                end
                                OP_BURST: state <= GET_LEN;
                                default: begin
                                    len_cnt <= '0;
                                    state   <= RAM_RD;
                                end
                            endcase
                        end else begin
                            fld_cnt <= fld_cnt - 8'd1;
                        end
                    end else if (tmo_hit) begin
                        err_count <= sat_inc(err_count);
                        state     <= IDLE;
                    end
                end

                GET_LEN: begin
                    if (rx_valid) begin
                        len_cnt <= rx_data;
                        state   <= RAM_RD;
                    end else if (tmo_hit) begin
                        err_count <= sat_inc(err_count);
                        state     <= IDLE;
                    end
                end

                GET_DATA: begin
                    if (rx_valid) begin
                        data_q <= DATA_W'({data_q, rx_data});
                        if (fld_cnt == 8'd0) begin
                            state <= RAM_WR;
                        end else begin
                            fld_cnt <= fld_cnt - 8'd1;
                        end
                    end else if (tmo_hit) begin
                        // Frame discarded before RAM_WR, so memory is untouched
                        err_count <= sat_inc(err_count);
                        state     <= IDLE;
                    end
                end

                RAM_WR: begin
                    tx_data  <= RSP_ACK;
                    tx_valid <= 1'b1;
                    state    <= ACK;
                end

                ACK, ERR: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end

                RAM_RD: begin
                    // Address is on the RAM this cycle; dout valid next cycle
                    state <= RD_WAIT;
                end

                RD_WAIT: begin
                    tx_data  <= ram_dout[DATA_W-1 -: 8];
                    shreg    <= ram_dout << 8;
                    byte_cnt <= 8'(BYTES - 1);
                    tx_valid <= 1'b1;
                    state    <= SEND;
                end

                SEND: begin
                    if (tx_ready) begin
                        if (byte_cnt != 8'd0) begin
                            // Next byte of the same word, no bubble
                            tx_data  <= shreg[DATA_W-1 -: 8];
                            shreg    <= shreg << 8;
                            byte_cnt <= byte_cnt - 8'd1;
                        end else begin
                            tx_valid <= 1'b0;
                            if (len_cnt != 8'd0) begin
                                len_cnt <= len_cnt - 8'd1;
                                addr_q  <= addr_q + ADDR_W'(1);  // wraps at DEPTH
                                state   <= RAM_RD;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Directed self-checking bench for uart_mem_bridge (8-bit and 16-bit words).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_uart_mem_bridge;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_valid, tx_ready, tx_valid, busy;
    logic [7:0] rx_data, tx_data, err_count;

    logic       rx2_valid, tx2_ready, tx2_valid, busy2;
    logic [7:0] rx2_data, tx2_data, err2_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_mem_bridge #(.DATA_W(8), .ADDR_W(4), .TIMEOUT_CYC(100)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .err_count(err_count)
    );

    uart_mem_bridge #(.DATA_W(16), .ADDR_W(4), .TIMEOUT_CYC(100)) dut16 (
        .clk(clk), .reset(reset), .rx_valid(rx2_valid), .rx_data(rx2_data),
        .tx_data(tx2_data), .tx_valid(tx2_valid), .tx_ready(tx2_ready),
        .busy(busy2), .err_count(err2_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send2(input logic [7:0] b);
        rx2_valid = 1'b1;
        rx2_data  = b;
        tick();
        rx2_valid = 1'b0;
    endtask

    // Wait (bounded) for a handshake on the 8-bit DUT, check the byte, consume it
    task automatic expect_byte(input string tag, input logic [7:0] exp);
        int w = 0;
        while (!(tx_valid && tx_ready) && w < 40) begin
            tick();
            w++;
        end
        chk({tag, "_hs"}, 32'(tx_valid && tx_ready), 32'd1);
        chk(tag, 32'(tx_data), 32'(exp));
        tick();
    endtask

    task automatic write_word(input logic [7:0] a, input logic [7:0] d);
        send(8'h57);
        send(a);
        send(d);
        expect_byte("preload_ack", 8'h4B);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
        rx2_valid = 1'b0; rx2_data = 8'h00; tx2_ready = 1'b1;
        repeat (3) tick();

        // Reset state
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'h00);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);
        reset = 1'b0;
        tick();

        // Write 'W' 03 A5: K appears in cycle 2
        send(8'h57); send(8'h03); send(8'hA5);
        chk("wr_c1_valid", 32'(tx_valid), 32'd0);
        chk("wr_c1_busy", 32'(busy), 32'd1);
        tick();
        chk("wr_c2_valid", 32'(tx_valid), 32'd1);
        chk("wr_c2_data", 32'(tx_data), 32'h4B);
        tick();
        chk("wr_c3_valid", 32'(tx_valid), 32'd0);
        chk("wr_c3_busy", 32'(busy), 32'd0);

        // Read 'R' 03: A5 appears in cycle 3
        send(8'h52); send(8'h03);
        chk("rd_c1_valid", 32'(tx_valid), 32'd0);
        tick();
        chk("rd_c2_valid", 32'(tx_valid), 32'd0);
        tick();
        chk("rd_c3_valid", 32'(tx_valid), 32'd1);
        chk("rd_c3_data", 32'(tx_data), 32'hA5);
        tick();
        chk("rd_c4_valid", 32'(tx_valid), 32'd0);

        // Preload mem[i] = i
        for (int i = 0; i < 16; i++) write_word(8'(i), 8'(i));

        // Burst from 0x0E, 4 words, wraps past 0x0F
        send(8'h42); send(8'h0E); send(8'h03);
        expect_byte("wrap0", 8'h0E);
        expect_byte("wrap1", 8'h0F);
        expect_byte("wrap2", 8'h00);
        expect_byte("wrap3", 8'h01);
        repeat (4) tick();
        chk("wrap_end_valid", 32'(tx_valid), 32'd0);
        chk("wrap_end_busy", 32'(busy), 32'd0);

        // Unknown opcode: '?' next cycle, one error
        send(8'h58);
        chk("bad_valid", 32'(tx_valid), 32'd1);
        chk("bad_data", 32'(tx_data), 32'h3F);
        chk("bad_err", 32'(err_count), 32'd1);
        tick();
        chk("bad_idle", 32'(busy), 32'd0);

        // Two bytes sent while a burst executes are dropped and counted
        send(8'h42); send(8'h00); send(8'h03);
        send(8'h52); send(8'h57);
        expect_byte("drop0", 8'h00);
        expect_byte("drop1", 8'h01);
        expect_byte("drop2", 8'h02);
        expect_byte("drop3", 8'h03);
        chk("drop_err", 32'(err_count), 32'd3);
        repeat (3) tick();
        chk("drop_idle", 32'(busy), 32'd0);

        // Backpressure: hold tx_ready low for 50 cycles on the second word
        send(8'h42); send(8'h04); send(8'h02);
        expect_byte("bp0", 8'h04);
        tx_ready = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 50; i++) begin
            chk("bp_stall", 32'({tx_valid, tx_data}), 32'h105);
            tick();
        end
        tx_ready = 1'b1;
        expect_byte("bp1", 8'h05);
        expect_byte("bp2", 8'h06);
        repeat (4) tick();
        chk("bp_end_valid", 32'(tx_valid), 32'd0);
        chk("bp_end_busy", 32'(busy), 32'd0);

        // Timeout in GET_DATA: expiry 100 cycles after the last byte
        send(8'h57); send(8'h05);
        repeat (99) tick();
        chk("tmo_pre_busy", 32'(busy), 32'd1);
        tick();
        chk("tmo_post_busy", 32'(busy), 32'd0);
        chk("tmo_err", 32'(err_count), 32'd4);
        send(8'h52); send(8'h05);
        expect_byte("tmo_old_val", 8'h05);

        // Byte delivered exactly in the expiry cycle is accepted
        send(8'h57);
        repeat (99) tick();
        send(8'h07);
        chk("edge_busy", 32'(busy), 32'd1);
        chk("edge_err", 32'(err_count), 32'd4);
        send(8'h77);
        expect_byte("edge_ack", 8'h4B);
        send(8'h52); send(8'h07);
        expect_byte("edge_rd", 8'h77);

        // Reset in the middle of a long burst
        send(8'h42); send(8'h00); send(8'h0F);
        expect_byte("rb0", 8'h00);
        expect_byte("rb1", 8'h01);
        tx_ready = 1'b0;
        for (int w = 0; w < 10 && !tx_valid; w++) tick();
        chk("rb_pre_valid", 32'(tx_valid), 32'd1);
        reset = 1'b1;
        tick();
        chk("rb_valid", 32'(tx_valid), 32'd0);
        chk("rb_data", 32'(tx_data), 32'h00);
        chk("rb_busy", 32'(busy), 32'd0);
        chk("rb_err", 32'(err_count), 32'd0);
        reset = 1'b0;
        tx_ready = 1'b1;
        tick();
        send(8'h52); send(8'h0E);
        expect_byte("rb_mem_e", 8'h0E);
        send(8'h52); send(8'h03);
        expect_byte("rb_mem_3", 8'h03);

        // 16-bit words: bytes MSB first, back-to-back within a word
        send2(8'h57); send2(8'h00); send2(8'h12); send2(8'h34);
        tick();
        chk("w16_ack_valid", 32'(tx2_valid), 32'd1);
        chk("w16_ack_data", 32'(tx2_data), 32'h4B);
        tick();
        send2(8'h52); send2(8'h00);
        tick(); tick();
        chk("r16_b0_valid", 32'(tx2_valid), 32'd1);
        chk("r16_b0_data", 32'(tx2_data), 32'h12);
        tick();
        chk("r16_b1_valid", 32'(tx2_valid), 32'd1);
        chk("r16_b1_data", 32'(tx2_data), 32'h34);
        tick();
        chk("r16_end_valid", 32'(tx2_valid), 32'd0);
        chk("r16_busy", 32'(busy2), 32'd0);
        chk("r16_err", 32'(err2_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
